phase_spike_emitter: RTL

Transmitter end of the gamma phase code. It converts queued phase values, such as L2/L3 predictions or replayed targets, back into spikes timed against the shared gamma oscillator. The phase-encoding neuron turns current into spike phase; this block turns a phase word into a spike at that phase of a later gamma cycle. It sits between a predictive layer's phase output and any downstream spiking consumer or stimulus path.

---
 rtl/phase_spike_emitter.sv | 89 ++++++++
 1 files changed

// File: rtl/phase_spike_emitter.sv
// phase_spike_emitter: replays queued phase words as spikes on the gamma cycle; PSE_HOLD_LAST_EN re-arms the last target when the queue is empty
module phase_spike_emitter #(
    parameter int DEPTH     = 4,
    parameter int CNT_W     = 3,
    parameter int CYCLE_LEN = 256,
    parameter int PULSE_LEN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cycle_start,
    input  logic [7:0]       global_phase,
    input  logic [7:0]       phase_in,
    input  logic             phase_valid,
    output logic             phase_ready,
    output logic             spike_out,
    output logic [7:0]       spike_phase,
    output logic             armed,
    output logic             missed,
    output logic [CNT_W-1:0] fifo_count
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, ARMED, FIRING, DONE} state_t;
    state_t state_q, state_d;
    logic [7:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0] tgt_q, tgt_d, sph_q, sph_d, cand;
    logic [3:0] pls_q, pls_d;
    logic spike_q, spike_d, missed_q, missed_d, push, pop, load, hit;
    assign push = phase_valid && phase_ready;
    assign pop = cycle_start && cnt_q != '0;
`ifdef PSE_HOLD_LAST_EN
    logic have_q, have_d;
    assign have_d = have_q || pop;
    assign load = pop || have_q;
    always_ff @(posedge clk) have_q <= rst ? 1'b0 : have_d;
`else
    assign load = pop;
`endif
    assign cand = pop ? mem_q[rd_q] : tgt_q;
    // the target loaded at cycle_start is already compared in that same clock
    assign hit = (cycle_start ? load : state_q == ARMED) && global_phase == cand && int'(cand) < CYCLE_LEN;
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= phase_in;
        if (rst) begin
            state_q  <= IDLE;
            wr_q     <= '0;
            rd_q     <= '0;
            cnt_q    <= '0;
            tgt_q    <= '0;
            sph_q    <= '0;
            pls_q    <= '0;
            spike_q  <= 1'b0;
            missed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            cnt_q    <= cnt_d;
            tgt_q    <= tgt_d;
            sph_q    <= sph_d;
            pls_q    <= pls_d;
            spike_q  <= spike_d;
            missed_q <= missed_d;
        end
    end
    always_comb begin
        state_d = state_q;
        if (cycle_start) state_d = !load ? IDLE : hit ? FIRING : ARMED;
        else if (hit) state_d = FIRING;
        else if (state_q == FIRING && pls_q >= 4'(PULSE_LEN)) state_d = DONE;
    end
    always_comb begin
        spike_d  = hit || (!cycle_start && state_q == FIRING && pls_q < 4'(PULSE_LEN));
        pls_d    = hit ? 4'd1 : spike_d ? pls_q + 4'd1 : pls_q;
        sph_d    = hit ? global_phase : sph_q;
        missed_d = cycle_start && state_q == ARMED;
        tgt_d    = cand;
        wr_d     = wr_q + AW'(push);
        rd_d     = rd_q + AW'(pop);
        cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
    end
    assign phase_ready = int'(cnt_q) < DEPTH;
    assign fifo_count  = cnt_q;
    assign spike_out   = spike_q;
    assign spike_phase = sph_q;
    assign armed       = state_q == ARMED;
    assign missed      = missed_q;
endmodule
